// File: rtl/branch_resolve.sv
// Branch resolution at the EX/MEM boundary: decides taken/not-taken, computes the target,
// owns the NZVC flag register and sequences the post-redirect pipeline flush.
module branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [63:0]      pc_in,
  input  logic [25:0]      BR_addr,
  input  logic [18:0]      COND_BR_addr,
  input  logic             UnCondBr,
  input  logic             cbz,
  input  logic             cond,
  input  logic             update,
  input  logic             negative,
  input  logic             zero,
  input  logic             overflow,
  input  logic             carry,
  output logic [63:0]      new_pc2,
  output logic             BrTaken,
  output logic             flush,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int unsigned FlushCntW = 3;
  localparam logic [FlushCntW-1:0] FlushLoad =
      FlushCntW'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);

  typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

  state_e               state_q, state_d;
  logic [FlushCntW-1:0] cnt_q, cnt_d;
  logic [63:0]          new_pc2_q, new_pc2_d;
  logic [3:0]           flags_d;
  logic [CNT_W-1:0]     taken_cnt_q, taken_cnt_d;

  logic        flag_upd;
  logic        n_eff;
  logic        v_eff;
  logic        taken;
  logic [63:0] offset;
  logic [63:0] target;

  // Flag register with same-cycle bypass into the condition evaluation.
  always_comb begin
    flag_upd = valid_in & update;
    flags_d  = flag_upd ? {negative, zero, overflow, carry} : flags_q;
    n_eff    = flag_upd ? negative : flags_q[3];
    v_eff    = flag_upd ? overflow : flags_q[1];
  end

  // Branch types are resolved in priority order UnCondBr > cbz > cond.
  always_comb begin
    taken = 1'b0;
    if (valid_in && (state_q == StIdle)) begin
      if (UnCondBr) begin
        taken = 1'b1;
      end else if (cbz) begin
        taken = zero;
      end else if (cond) begin
        taken = n_eff ^ v_eff;
      end
    end
  end

  always_comb begin
    if (UnCondBr) begin
      offset = {{36{BR_addr[25]}}, BR_addr, 2'b00};
    end else begin
      offset = {{43{COND_BR_addr[18]}}, COND_BR_addr, 2'b00};
    end
    target = pc_in + offset;
  end

  always_comb begin
    new_pc2_d   = taken ? target : new_pc2_q;
    taken_cnt_d = taken_cnt_q;
    if (taken && (taken_cnt_q != {CNT_W{1'b1}})) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (taken) begin
          state_d = StRedirect;
        end
      end
      StRedirect: begin
        if (FLUSH_CYCLES <= 1) begin
          state_d = StIdle;
        end else begin
          cnt_d   = FlushLoad;
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - FlushCntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      new_pc2_q   <= '0;
      flags_q     <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      new_pc2_q   <= new_pc2_d;
      flags_q     <= flags_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  // Outputs decode directly from registered state, so they are glitch-free.
  always_comb begin
    new_pc2   = new_pc2_q;
    BrTaken   = (state_q == StRedirect);
    flush     = (state_q != StIdle);
    taken_cnt = taken_cnt_q;
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed cases plus randomized traffic
// compared every cycle against a cycle-count based reference model.
module tb_branch_resolve;

  localparam int unsigned FlushCycles = 2;
  localparam int unsigned CntW        = 4;

  logic            clk;
  logic            reset;
  logic            valid_in;
  logic [63:0]     pc_in;
  logic [25:0]     BR_addr;
  logic [18:0]     COND_BR_addr;
  logic            UnCondBr;
  logic            cbz;
  logic            cond;
  logic            update;
  logic            negative;
  logic            zero;
  logic            overflow;
  logic            carry;
  logic [63:0]     new_pc2;
  logic            BrTaken;
  logic            flush;
  logic [3:0]      flags_q;
  logic [CntW-1:0] taken_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [63:0] m_pc;
  logic        m_br;
  int          m_busy;
  logic [3:0]  m_flags;
  int unsigned m_cnt;

  branch_resolve #(
    .FLUSH_CYCLES(FlushCycles),
    .CNT_W       (CntW)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .pc_in       (pc_in),
    .BR_addr     (BR_addr),
    .COND_BR_addr(COND_BR_addr),
    .UnCondBr    (UnCondBr),
    .cbz         (cbz),
    .cond        (cond),
    .update      (update),
    .negative    (negative),
    .zero        (zero),
    .overflow    (overflow),
    .carry       (carry),
    .new_pc2     (new_pc2),
    .BrTaken     (BrTaken),
    .flush       (flush),
    .flags_q     (flags_q),
    .taken_cnt   (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    valid_in     = 1'b0;
    pc_in        = '0;
    BR_addr      = '0;
    COND_BR_addr = '0;
    UnCondBr     = 1'b0;
    cbz          = 1'b0;
    cond         = 1'b0;
    update       = 1'b0;
    negative     = 1'b0;
    zero         = 1'b0;
    overflow     = 1'b0;
    carry        = 1'b0;
  endtask

  // Advances the model by one clock using the inputs as they stand before the edge.
  task automatic model_step();
    logic       upd;
    logic [3:0] fl;
    logic       t;
    longint     off;
    if (reset) begin
      m_pc    = '0;
      m_br    = 1'b0;
      m_busy  = 0;
      m_flags = '0;
      m_cnt   = 0;
      return;
    end
    upd = valid_in && update;
    fl  = upd ? {negative, zero, overflow, carry} : m_flags;
    t   = 1'b0;
    if (valid_in && m_busy == 0) begin
      if (UnCondBr) t = 1'b1;
      else if (cbz) t = zero;
      else if (cond) t = (fl[3] != fl[1]);
    end
    if (UnCondBr) off = longint'($signed(BR_addr)) * 4;
    else off = longint'($signed(COND_BR_addr)) * 4;
    if (t) begin
      m_pc   = pc_in + 64'(off);
      m_br   = 1'b1;
      m_busy = FlushCycles;
      if (m_cnt < (2 ** CntW) - 1) m_cnt++;
    end else begin
      m_br = 1'b0;
      if (m_busy > 0) m_busy--;
    end
    m_flags = fl;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_eq("new_pc2", new_pc2, m_pc);
    check_eq("BrTaken", 64'(BrTaken), 64'(m_br));
    check_eq("flush", 64'(flush), 64'(m_busy > 0));
    check_eq("flags_q", 64'(flags_q), 64'(m_flags));
    check_eq("taken_cnt", 64'(taken_cnt), 64'(m_cnt));
  endtask

  task automatic idle_cycles(input int n);
    clear_in();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic issue_b(input logic [63:0] pc, input logic [25:0] imm);
    clear_in();
    valid_in = 1'b1;
    pc_in    = pc;
    UnCondBr = 1'b1;
    BR_addr  = imm;
    cycle();
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    m_pc = '0; m_br = 1'b0; m_busy = 0; m_flags = '0; m_cnt = 0;
    cycle();
    cycle();
    reset = 1'b0;
    check_eq("rst_pc", new_pc2, 64'h0);
    check_eq("rst_flush", 64'(flush), 64'h0);

    // B with imm26 = -1 word.
    issue_b(64'h100, 26'h3FFFFFF);
    check_eq("b_pc", new_pc2, 64'hFC);
    check_eq("b_taken", 64'(BrTaken), 64'h1);
    check_eq("b_cnt", 64'(taken_cnt), 64'h1);
    clear_in();
    cycle();
    check_eq("b_flush2", 64'(flush), 64'h1);
    check_eq("b_pulse", 64'(BrTaken), 64'h0);
    cycle();
    check_eq("b_flush_end", 64'(flush), 64'h0);

    // Second branch right behind a taken one is squashed.
    issue_b(64'h100, 26'd4);
    issue_b(64'h200, 26'd8);
    check_eq("sq_pc", new_pc2, 64'h110);
    check_eq("sq_cnt", 64'(taken_cnt), 64'h2);
    idle_cycles(2);

    clear_in();
    valid_in = 1'b1; pc_in = 64'h40; cbz = 1'b1; COND_BR_addr = 19'd4; zero = 1'b1;
    cycle();
    check_eq("cbz_pc", new_pc2, 64'h50);
    idle_cycles(2);
    valid_in = 1'b1; pc_in = 64'h40; cbz = 1'b1; COND_BR_addr = 19'd4; zero = 1'b0;
    cycle();
    check_eq("cbz_nt_br", 64'(BrTaken), 64'h0);
    check_eq("cbz_nt_fl", 64'(flush), 64'h0);

    // B.LT from the flag register.
    clear_in();
    valid_in = 1'b1; update = 1'b1; negative = 1'b1;
    cycle();
    check_eq("lt_flags", 64'(flags_q), 64'h8);
    clear_in();
    valid_in = 1'b1; cond = 1'b1; COND_BR_addr = 19'd1; pc_in = 64'h8;
    cycle();
    check_eq("lt_pc", new_pc2, 64'hC);
    check_eq("lt_taken", 64'(BrTaken), 64'h1);
    idle_cycles(2);
    valid_in = 1'b1; update = 1'b1; negative = 1'b1; overflow = 1'b1;
    cycle();
    clear_in();
    valid_in = 1'b1; cond = 1'b1; COND_BR_addr = 19'd1; pc_in = 64'h8;
    cycle();
    check_eq("ge_nt", 64'(BrTaken), 64'h0);

    // Bypass: incoming N=1,V=0 over a cleared flag register.
    clear_in();
    valid_in = 1'b1; update = 1'b1;
    cycle();
    clear_in();
    valid_in = 1'b1; update = 1'b1; cond = 1'b1; negative = 1'b1;
    pc_in = 64'h1000; COND_BR_addr = 19'd2;
    cycle();
    check_eq("byp_taken", 64'(BrTaken), 64'h1);
    check_eq("byp_pc", new_pc2, 64'h1008);
    idle_cycles(2);

    issue_b(64'hFFFF_FFFF_FFFF_FFFC, 26'd2);
    check_eq("wrap_pc", new_pc2, 64'h4);
    idle_cycles(2);

    // UnCondBr outranks cbz: offset comes from BR_addr.
    clear_in();
    valid_in = 1'b1; UnCondBr = 1'b1; cbz = 1'b1; zero = 1'b1;
    BR_addr = 26'd1; COND_BR_addr = 19'd5;
    cycle();
    check_eq("prio_pc", new_pc2, 64'h4);
    idle_cycles(2);

    // Reset held for two cycles while in the flush tail.
    issue_b(64'h300, 26'd1);
    clear_in();
    cycle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    check_eq("mid_rst_pc", new_pc2, 64'h0);
    check_eq("mid_rst_fl", 64'(flush), 64'h0);
    check_eq("mid_rst_cnt", 64'(taken_cnt), 64'h0);
    cycle();
    check_eq("post_rst_fl", 64'(flush), 64'h0);

    for (int i = 0; i < 18; i++) begin
      issue_b(64'(i) * 64'h10, 26'd3);
      idle_cycles(2);
    end
    check_eq("sat_cnt", 64'(taken_cnt), 64'hF);

    for (int i = 0; i < 3000; i++) begin
      int unsigned kind;
      clear_in();
      reset        = ($urandom_range(0, 99) == 0);
      valid_in     = ($urandom_range(0, 7) != 0);
      pc_in        = {$urandom(), $urandom()};
      BR_addr      = 26'($urandom());
      COND_BR_addr = 19'($urandom());
      update       = $urandom_range(0, 1) == 1;
      {negative, zero, overflow, carry} = 4'($urandom());
      kind = $urandom_range(0, 3);
      UnCondBr     = (kind == 1);
      cbz          = (kind == 2);
      cond         = (kind == 3);
      cycle();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
